// File: rtl/block_dispatcher.sv
// block_dispatcher: kernel-launch front end that hands block IDs to free compute cores
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   start          launch request, honoured only while idle
//   kernel_config  {num_blocks[127:96], num_warps_per_block[95:64],
//                   base_instr_addr[63:32], base_data_addr[31:0]}
//   core_done      per-core block-retire pulses
//   core_start     one-hot dispatch pulse; core_block_id carries its block ID
//   cfg_*          latched kernel configuration, stable while busy
//   busy           high whenever a kernel is in flight (any state but IDLE)
//   kernel_done    one-cycle completion pulse
//   kernel_cycles  busy-cycle counter, built only with BLOCK_DISPATCHER_PERF_EN defined
module block_dispatcher #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [127:0]         kernel_config,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] core_start,
    output logic [31:0]          core_block_id,
    output logic [31:0]          cfg_warps_per_block,
    output logic [31:0]          cfg_base_instr_addr,
    output logic [31:0]          cfg_base_data_addr,
    output logic                 busy,
    output logic                 kernel_done,
    output logic [31:0]          kernel_cycles
);
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
    state_t state, state_next;
    logic [NUM_CORES-1:0] core_busy, free_oh, retire_mask;
    logic [31:0] num_blocks, dispatched, retired, retire_cnt, retired_next;
    logic free_any, accept, dispatch;
    // Highest-index free core wins; selection uses the registered busy bits so
    // a core freed this cycle only becomes eligible next cycle.
    always_comb begin
        free_oh = '0;
        free_any = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!core_busy[i]) begin
                free_oh = '0;
                free_oh[i] = 1'b1;
                free_any = 1'b1;
            end
        end
    end
    // Completions on cores that hold no block are ignored.
    always_comb begin
        retire_mask = core_done & core_busy;
        retire_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) retire_cnt = retire_cnt + 32'(retire_mask[i]);
    end
    assign retired_next = retired + retire_cnt;
    assign accept = state == IDLE && start;
    assign dispatch = state == DISPATCH && free_any && dispatched < num_blocks;
    assign busy = state != IDLE;
    assign kernel_done = state == DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    // The final retirement always lands in DONE on the same edge, even if it
    // arrives while the last dispatch is still being closed out.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = kernel_config[127:96] == 32'd0 ? DONE : DISPATCH;
            DISPATCH: if (dispatched == num_blocks) state_next = retired_next == num_blocks ? DONE : DRAIN;
            DRAIN:    if (retired_next == num_blocks) state_next = DONE;
            DONE:     state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_start <= '0;
            core_block_id <= '0;
            core_busy <= '0;
            dispatched <= '0;
            retired <= '0;
            num_blocks <= '0;
            cfg_warps_per_block <= '0;
            cfg_base_instr_addr <= '0;
            cfg_base_data_addr <= '0;
        end else begin
            core_start <= dispatch ? free_oh : '0;
            core_busy <= (core_busy & ~retire_mask) | (dispatch ? free_oh : '0);
            dispatched <= accept ? '0 : dispatched + 32'(dispatch);
            retired <= accept ? '0 : retired_next;
            if (dispatch) core_block_id <= dispatched;
            if (accept) begin
                num_blocks <= kernel_config[127:96];
                cfg_warps_per_block <= kernel_config[95:64];
                cfg_base_instr_addr <= kernel_config[63:32];
                cfg_base_data_addr <= kernel_config[31:0];
            end
        end
    end
`ifdef BLOCK_DISPATCHER_PERF_EN
    // Counts every busy cycle, including the DONE cycle, then holds once idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) kernel_cycles <= '0;
        else if (accept) kernel_cycles <= '0;
        else if (busy) kernel_cycles <= kernel_cycles + 32'd1;
    end
`else
    assign kernel_cycles = '0;
`endif
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: randomized scoreboard bench for block_dispatcher with emulated cores
module tb_block_dispatcher;
    localparam int NC = 4;
    logic clk = 1'b0;
    logic reset, start;
    logic [127:0] kernel_config;
    logic [NC-1:0] core_done, core_start;
    logic [31:0] core_block_id, cfg_warps_per_block, cfg_base_instr_addr, cfg_base_data_addr, kernel_cycles;
    logic busy, kernel_done;

    block_dispatcher #(.NUM_CORES(NC)) dut (
        .clk(clk), .reset(reset), .start(start), .kernel_config(kernel_config),
        .core_done(core_done), .core_start(core_start), .core_block_id(core_block_id),
        .cfg_warps_per_block(cfg_warps_per_block), .cfg_base_instr_addr(cfg_base_instr_addr),
        .cfg_base_data_addr(cfg_base_data_addr), .busy(busy), .kernel_done(kernel_done),
        .kernel_cycles(kernel_cycles)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic [NC-1:0] oh;
        logic [31:0] id;
        bit          done;
        logic [31:0] cyc, w, ia, da;
    } ev_t;
    ev_t q[$];

    int checks = 0, errors = 0, edge_n = 0;
    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: free-core set, next block, retired count, plus per-core
    // countdowns that emulate each core working on its block.
    bit m_free[NC];
    int cnt[NC];
    bit m_active;
    int m_nb, m_next, m_ret, m_t, idle_until, cur_mode;
    logic [31:0] m_w, m_ia, m_da;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_free[i] = 1'b1;
            cnt[i] = 0;
        end
        m_active = 1'b0;
        idle_until = 0;
    endtask

    function automatic int lat_of(input int idx);
        case (cur_mode)
            1: return 5 - idx;
            2: return 5;
            3: return 60;
            default: return int'($urandom_range(2, 7));
        endcase
    endfunction

    function automatic logic [127:0] rnd_cfg();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives the inputs for the next rising edge and predicts that edge's outcome.
    task automatic step(input bit st, input logic [127:0] cfg);
        logic [NC-1:0] d;
        int e, sel;
        ev_t ev;
        @(negedge clk);
        e = edge_n + 1;
        d = '0;
        for (int i = 0; i < NC; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) d[i] = 1'b1;
            end else if (m_free[i] && $urandom_range(0, 4) == 0) d[i] = 1'b1;
        end
        start = st;
        kernel_config = cfg;
        core_done = d;
        if (!m_active) begin
            if (st && e >= idle_until) begin
                m_nb = int'(cfg[127:96]);
                m_w = cfg[95:64];
                m_ia = cfg[63:32];
                m_da = cfg[31:0];
                m_next = 0;
                m_ret = 0;
                m_t = e;
                if (m_nb == 0) begin
                    ev = '{stamp: e, oh: '0, id: 0, done: 1'b1, cyc: 32'd1, w: 0, ia: 0, da: 0};
                    q.push_back(ev);
                    idle_until = e + 2;
                end else m_active = 1'b1;
            end
        end else begin
            sel = -1;
            if (m_next < m_nb)
                for (int i = 0; i < NC; i++) if (m_free[i]) sel = i;
            for (int i = 0; i < NC; i++)
                if (d[i] && !m_free[i]) begin
                    m_free[i] = 1'b1;
                    m_ret++;
                end
            if (sel >= 0) begin
                ev = '{stamp: e, oh: NC'(1) << sel, id: 32'(m_next), done: 1'b0, cyc: 0, w: m_w, ia: m_ia, da: m_da};
                q.push_back(ev);
                m_free[sel] = 1'b0;
                cnt[sel] = lat_of(m_next);
                m_next++;
            end
            if (m_ret == m_nb) begin
                ev = '{stamp: e, oh: '0, id: 0, done: 1'b1, cyc: 32'(e + 1 - m_t), w: 0, ia: 0, da: 0};
                q.push_back(ev);
                m_active = 1'b0;
                idle_until = e + 2;
            end
        end
    endtask

    task automatic wait_idle();
        while (m_active || edge_n + 1 < idle_until) step(1'b0, rnd_cfg());
    endtask

    // Launches a kernel, sprinkles ignored start requests while it runs and
    // once more during the DONE cycle.
    task automatic run_kernel(input logic [31:0] nb, input int mode);
        wait_idle();
        cur_mode = mode;
        step(1'b1, {nb, $urandom(), $urandom(), $urandom()});
        while (m_active) step($urandom_range(0, 7) == 0, rnd_cfg());
        step(1'b1, rnd_cfg());
        step(1'b0, rnd_cfg());
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_core_block_id"}, core_block_id, 32'd0);
        check({tag, "_cfg_warps"}, cfg_warps_per_block, 32'd0);
        check({tag, "_cfg_instr"}, cfg_base_instr_addr, 32'd0);
        check({tag, "_cfg_data"}, cfg_base_data_addr, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_kernel_done"}, 32'(kernel_done), 32'd0);
        check({tag, "_kernel_cycles"}, kernel_cycles, 32'd0);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a dispatch or completion.
    initial begin
        ev_t ev;
        bit post_chk;
        logic [31:0] exp_cyc;
        post_chk = 1'b0;
        exp_cyc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                post_chk = 1'b0;
                continue;
            end
            if (post_chk) begin
                post_chk = 1'b0;
                check("busy_after_done", 32'(busy), 32'd0);
`ifdef BLOCK_DISPATCHER_PERF_EN
                check("kernel_cycles", kernel_cycles, exp_cyc);
`else
                check("kernel_cycles", kernel_cycles, 32'd0);
`endif
            end
            if (core_start != '0 || kernel_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got core_start=%b kernel_done=%b, expected none", core_start, kernel_done);
                end else begin
                    ev = q.pop_front();
                    check("event_edge", 32'(edge_n), 32'(ev.stamp));
                    check("core_start", 32'(core_start), 32'(ev.oh));
                    check("kernel_done", 32'(kernel_done), 32'(ev.done));
                    check("busy", 32'(busy), 32'd1);
                    if (!ev.done) begin
                        check("core_block_id", core_block_id, ev.id);
                        check("cfg_warps", cfg_warps_per_block, ev.w);
                        check("cfg_instr", cfg_base_instr_addr, ev.ia);
                        check("cfg_data", cfg_base_data_addr, ev.da);
                    end else begin
                        post_chk = 1'b1;
                        exp_cyc = ev.cyc;
                    end
                end
            end
            while (q.size() > 0 && q[0].stamp < edge_n) begin
                checks++;
                errors++;
                $display("FAIL missed_output: got nothing, expected core_start=%b id=%0d done=%b at edge %0d",
                         q[0].oh, q[0].id, q[0].done, q[0].stamp);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        kernel_config = '0;
        core_done = '0;
        cur_mode = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        run_kernel(32'd4, 3);
        run_kernel(32'd6, 0);
        run_kernel(32'd0, 0);
        run_kernel(32'd4, 1);
        run_kernel(32'd1, 2);
        wait_idle();
        cur_mode = 0;
        step(1'b1, {32'd6, $urandom(), $urandom(), $urandom()});
        while (m_next < 2) step(1'b0, rnd_cfg());
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        q.delete();
        model_reset();
        start = 1'b0;
        core_done = '0;
        @(negedge clk);
        reset = 1'b0;
        run_kernel(32'd1, 0);
        for (int k = 0; k < 20; k++) run_kernel(32'($urandom_range(0, 10)), 0);
        repeat (5) step(1'b0, rnd_cfg());
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_dispatcher.md
# block_dispatcher

Kernel-launch front end of the GPU. Latches a `kernel_config_t` on `start`, hands out block IDs 0..num_blocks-1 one at a time to free compute cores, tracks per-core busy state from core completion pulses, and signals kernel completion once every block has finished. Sits between the host/control interface and the core array. Each core's warp scheduler consumes the dispatched block ID and the latched config.

## Interface
Parameters:
- `NUM_CORES`, 4: number of compute cores. Must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch request; honoured only in IDLE.
- `kernel_config`  in  `kernel_config_t` (128)  sampled on an accepted `start`.
- `core_done`  in  NUM_CORES  one-cycle pulse per core when its block retires.
- `core_start`  out  NUM_CORES  one-hot, one-cycle pulse assigning a block to a core.
- `core_block_id`  out  32  block ID; valid while `core_start` is nonzero.
- `cfg_warps_per_block`  out  32  latched `num_warps_per_block`; stable while `busy`.
- `cfg_base_instr_addr`  out  32  latched; stable while `busy`.
- `cfg_base_data_addr`  out  32  latched; stable while `busy`.
- `busy`  out  1  high in every state except IDLE.
- `kernel_done`  out  1  one-cycle pulse when the kernel completes.
- `kernel_cycles`  out  32  performance counter; see Configuration.

## Operation
- States:
  - IDLE: waits for `start`.
  - DISPATCH: issues blocks to cores.
  - DRAIN: all blocks issued; waits for completions.
  - DONE: one cycle, drives `kernel_done`.
- Transitions:
  - IDLE→DISPATCH on `start` with num_blocks≠0; latch config, clear counters.
  - IDLE→DONE on `start` with num_blocks=0.
  - DISPATCH→DRAIN when `dispatched == num_blocks`.
  - DRAIN→DONE when `retired == num_blocks`.
  - DONE→IDLE unconditionally.
- Internal registers:
  - `core_busy[NUM_CORES]`.
  - `dispatched` (32b): next block ID.
  - `retired` (32b).
- Dispatch: in DISPATCH, if any core has `core_busy=0` and `dispatched < num_blocks`, select the highest-index free core. Register `core_start` one-hot for it, register `core_block_id=dispatched`, set its busy bit, and increment `dispatched`. At most one dispatch per cycle.
- Retire: for each bit with `core_done[i]=1` and `core_busy[i]=1`, clear the busy bit. `retired` increases by the popcount of those bits. `core_done` on a non-busy core is ignored.
- Simultaneous retire and dispatch in the same cycle are both applied. A core freed in cycle t is eligible for dispatch from cycle t+1, not the same cycle.
- `start` outside IDLE is ignored. Config inputs are not re-sampled.
- Counters are 32-bit. num_blocks ≤ 2^32−1, so no wrap occurs.

## Timing
- Reset values: state IDLE; all of the following are 0: `core_start`, `core_block_id`, `cfg_*`, `busy`, `kernel_done`, `kernel_cycles`, `core_busy`, `dispatched`, `retired`.
- Reset mid-kernel returns to IDLE immediately (asynchronous) and drops all busy bits. Cores are reset by the same signal.
- `start` accepted at edge t: `busy` is high from t. The first `core_start` pulse is high during the cycle after edge t+1.
- With all cores free, blocks 0..NUM_CORES−1 issue on consecutive cycles.
- `core_done` sampled at edge u frees the core from u. The next dispatch to that core occurs at the earliest at edge u+1.
- Completion: the final retirement at edge r moves the state to DONE. `kernel_done` is high for the cycle after edge r, and `busy` drops at r+1.
- Zero-block kernel: `kernel_done` follows `start` by one cycle, and `core_start` never fires.

## Configuration
- `BLOCK_DISPATCHER_PERF_EN` defined:
  - `kernel_cycles` clears on an accepted `start` and increments every cycle while `busy`.
  - It freezes on `kernel_done` and holds until the next accepted `start`.
- Not defined: `kernel_cycles` is tied to 0 and no counter logic is built. The port list is identical in both builds.

## Test plan
- NUM_CORES=4, num_blocks=4, no `core_done` -> `core_start` = 1000, 0100, 0010, 0001 on four consecutive cycles with IDs 0,1,2,3. State stays DRAIN and `kernel_done` stays 0.
- NUM_CORES=4, num_blocks=6, pulse `core_done`=0100 after all four issue -> next `core_start`=0100 with ID 4, one cycle after the pulse. Then free 0001 -> ID 5 to core 0. Retire all -> one `kernel_done` pulse, then `busy`=0.
- num_blocks=0 -> `kernel_done` high one cycle after `start`. `core_start` always 0.
- Same-cycle `core_done`=1111 with 4 blocks busy and num_blocks=4 -> `retired` jumps 0→4 and DONE next cycle. A spurious `core_done` on an idle core leaves `retired` unchanged.
- Assert `reset` while in DISPATCH with 2 blocks issued -> all outputs 0 immediately. A new `start` with num_blocks=1 then issues ID 0 correctly.
- With `BLOCK_DISPATCHER_PERF_EN` defined, num_blocks=1, core responds 5 cycles after `core_start` -> `kernel_cycles` equals the `busy`-high cycle count and holds after `kernel_done`. Without the macro it reads 0.
